// File: rtl/matrix_pkg.sv
// Shared constants and address arithmetic for the matrix slot manager.
// Slots are packed by row count, then column count, then slot index.
package matrix_pkg;

   localparam int unsigned MAX_DIM = 5;
   localparam int unsigned SLOTS   = 2;
   localparam int unsigned ADDR_W  = 9;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned COMBOS  = MAX_DIM * MAX_DIM;
   localparam int unsigned CIDX_W  = $clog2(COMBOS);

   typedef enum logic [1:0] {IDLE, CALC, READY, BUSY} state_t;

   function automatic logic dims_ok(input logic [2:0] m, input logic [2:0] n);
      return (32'(m) >= 1) && (32'(m) <= MAX_DIM) &&
             (32'(n) >= 1) && (32'(n) <= MAX_DIM);
   endfunction

   function automatic logic [CIDX_W-1:0] combo_idx(input logic [2:0] m, input logic [2:0] n);
      return CIDX_W'((32'(m) - 1) * MAX_DIM + 32'(n) - 1);
   endfunction

   // 15*m*(m-1) covers every smaller row count across all n and both slots.
   function automatic logic [ADDR_W-1:0] slot_base(input logic [2:0] m, input logic [2:0] n,
                                                   input logic s);
      int unsigned mi;
      int unsigned ni;
      logic [9:0]  full;
      mi   = 32'(m);
      ni   = 32'(n);
      full = 10'(15 * mi * (mi - 1) + mi * ni * (ni - 1) + (s ? mi * ni : 0));
      return ADDR_W'(full);
   endfunction

endpackage

// File: rtl/write_port_arbiter.sv
// Fixed-priority mux for the single RAM write port: input path beats compute writer.
// Address and data hold their last written values while the port is idle.
module write_port_arbiter
   import matrix_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_we,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   input  logic              cp_req,
   input  logic [ADDR_W-1:0] cp_addr,
   input  logic [DATA_W-1:0] cp_data,
   output logic              cp_gnt,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data
);

   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;

   always_comb begin
      cp_gnt   = 1'b0;
      mem_we   = 1'b0;
      mem_addr = addr_q;
      mem_data = data_q;
      if (!rst) begin
         if (in_we) begin
            mem_we   = 1'b1;
            mem_addr = in_addr;
            mem_data = in_data;
         end else if (cp_req) begin
            cp_gnt   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = cp_addr;
            mem_data = cp_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
         data_q <= '0;
      end else if (mem_we) begin
         addr_q <= mem_addr;
         data_q <= mem_data;
      end
   end

endmodule

// File: rtl/matrix_slot_manager.sv
// Allocates matrix RAM slots per (m,n), tracks their validity, serves lookups
// and owns the shared RAM write port.
module matrix_slot_manager
   import matrix_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_req,
   input  logic [2:0]        alloc_m,
   input  logic [2:0]        alloc_n,
   input  logic              commit,
   input  logic              abort,
   input  logic              clear_all,
   output logic [ADDR_W-1:0] base_addr,
   output logic              addr_ready,
   output logic              alloc_err,
   output logic [1:0]        alloc_id,
   input  logic [2:0]        lk_m,
   input  logic [2:0]        lk_n,
   input  logic [1:0]        lk_id,
   output logic [ADDR_W-1:0] lk_base,
   output logic              lk_hit,
   output logic [1:0]        lk_count,
   input  logic              in_we,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_data,
   input  logic              cp_req,
   input  logic [ADDR_W-1:0] cp_addr,
   input  logic [DATA_W-1:0] cp_data,
   output logic              cp_gnt,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data
);

   state_t            state;
   logic [2:0]        m_q;
   logic [2:0]        n_q;
   logic              slot_q;
   logic [1:0]        valid [COMBOS];
   logic              ptr   [COMBOS];

   logic [CIDX_W-1:0] cidx;
   logic              pick;
   logic              lk_dims;
   logic              lk_ok;
   logic [CIDX_W-1:0] lk_c;
   logic              lk_s;

   always_comb begin
      cidx = dims_ok(m_q, n_q) ? combo_idx(m_q, n_q) : '0;
      if (!valid[cidx][0])      pick = 1'b0;
      else if (!valid[cidx][1]) pick = 1'b1;
      else                      pick = ptr[cidx];
   end

   always_comb begin
      lk_dims = dims_ok(lk_m, lk_n);
      lk_ok   = lk_dims && (lk_id != 2'd0) && (32'(lk_id) <= SLOTS);
      lk_c    = lk_dims ? combo_idx(lk_m, lk_n) : '0;
      lk_s    = 1'(lk_id - 2'd1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         m_q        <= '0;
         n_q        <= '0;
         slot_q     <= 1'b0;
         base_addr  <= '0;
         alloc_id   <= '0;
         addr_ready <= 1'b0;
         alloc_err  <= 1'b0;
         for (int unsigned i = 0; i < COMBOS; i++) begin
            valid[i] <= '0;
            ptr[i]   <= 1'b0;
         end
      end else begin
         addr_ready <= 1'b0;
         alloc_err  <= 1'b0;
         if (clear_all) begin
            state <= IDLE;
            for (int unsigned i = 0; i < COMBOS; i++) begin
               valid[i] <= '0;
               ptr[i]   <= 1'b0;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (alloc_req) begin
                     m_q <= alloc_m;
                     n_q <= alloc_n;
                     if (dims_ok(alloc_m, alloc_n)) state <= CALC;
                     else                           alloc_err <= 1'b1;
                  end
               end
               CALC: begin
                  // Victim slot is invalidated as READY is entered so lookups miss until commit.
                  slot_q            <= pick;
                  base_addr         <= slot_base(m_q, n_q, pick);
                  alloc_id          <= {1'b0, pick} + 2'd1;
                  valid[cidx][pick] <= 1'b0;
                  addr_ready        <= 1'b1;
                  state             <= READY;
               end
               READY: state <= BUSY;
               BUSY: begin
                  // A new alloc_req while busy closes out the current slot as if committed.
                  if (commit || alloc_req) begin
                     valid[cidx][slot_q] <= 1'b1;
                     ptr[cidx]           <= ~slot_q;
                     if (alloc_req) begin
                        m_q <= alloc_m;
                        n_q <= alloc_n;
                        if (dims_ok(alloc_m, alloc_n)) begin
                           state <= CALC;
                        end else begin
                           alloc_err <= 1'b1;
                           state     <= IDLE;
                        end
                     end else begin
                        state <= IDLE;
                     end
                  end else if (abort) begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lk_base  <= '0;
         lk_hit   <= 1'b0;
         lk_count <= '0;
      end else begin
         lk_hit   <= lk_ok && valid[lk_c][lk_s];
         lk_base  <= lk_ok ? slot_base(lk_m, lk_n, lk_s) : '0;
         lk_count <= lk_dims ? (2'(valid[lk_c][0]) + 2'(valid[lk_c][1])) : '0;
      end
   end

   write_port_arbiter u_arb (
      .clk      (clk),
      .rst      (rst),
      .in_we    (in_we),
      .in_addr  (in_addr),
      .in_data  (in_data),
      .cp_req   (cp_req),
      .cp_addr  (cp_addr),
      .cp_data  (cp_data),
      .cp_gnt   (cp_gnt),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_data (mem_data)
   );

endmodule

// File: tb/tb_matrix_slot_manager.sv
// Directed bench for matrix_slot_manager; inputs change on the falling edge.
module tb_matrix_slot_manager;

   logic        clk = 1'b0;
   logic        rst;
   logic        alloc_req, commit, abort, clear_all;
   logic [2:0]  alloc_m, alloc_n, lk_m, lk_n;
   logic [1:0]  lk_id, alloc_id, lk_count;
   logic [8:0]  base_addr, lk_base, in_addr, cp_addr, mem_addr;
   logic        addr_ready, alloc_err, lk_hit, in_we, cp_req, cp_gnt, mem_we;
   logic [31:0] in_data, cp_data, mem_data;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   matrix_slot_manager dut (
      .clk(clk), .rst(rst),
      .alloc_req(alloc_req), .alloc_m(alloc_m), .alloc_n(alloc_n),
      .commit(commit), .abort(abort), .clear_all(clear_all),
      .base_addr(base_addr), .addr_ready(addr_ready), .alloc_err(alloc_err), .alloc_id(alloc_id),
      .lk_m(lk_m), .lk_n(lk_n), .lk_id(lk_id),
      .lk_base(lk_base), .lk_hit(lk_hit), .lk_count(lk_count),
      .in_we(in_we), .in_addr(in_addr), .in_data(in_data),
      .cp_req(cp_req), .cp_addr(cp_addr), .cp_data(cp_data), .cp_gnt(cp_gnt),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data)
   );

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_alloc(input logic [2:0] m, input logic [2:0] n);
      alloc_req = 1'b1; alloc_m = m; alloc_n = n;
      @(negedge clk);
      alloc_req = 1'b0;
   endtask

   task automatic do_commit();
      commit = 1'b1;
      @(negedge clk);
      commit = 1'b0;
   endtask

   task automatic do_lookup(input logic [2:0] m, input logic [2:0] n, input logic [1:0] id);
      lk_m = m; lk_n = n; lk_id = id;
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) step();
      total_cnt++; if ({addr_ready, alloc_err, alloc_id, base_addr} !== 14'd0) $display("FAIL reset_alloc_outs: got %h want 0", {addr_ready, alloc_err, alloc_id, base_addr}); else pass_cnt++;
      total_cnt++; if ({lk_hit, lk_count, lk_base} !== 12'd0) $display("FAIL reset_lookup_outs: got %h want 0", {lk_hit, lk_count, lk_base}); else pass_cnt++;
      total_cnt++; if ({cp_gnt, mem_we, mem_addr, mem_data} !== 43'd0) $display("FAIL reset_mem_outs: got %h want 0", {cp_gnt, mem_we, mem_addr, mem_data}); else pass_cnt++;
      rst = 1'b0;
      step();
   endtask

   task automatic test_alloc_basic();
      do_alloc(3'd2, 3'd3);
      total_cnt++; if (addr_ready !== 1'b0) $display("FAIL a23_early_ready: got %b want 0", addr_ready); else pass_cnt++;
      step();
      total_cnt++; if (addr_ready !== 1'b1) $display("FAIL a23_ready: got %b want 1", addr_ready); else pass_cnt++;
      total_cnt++; if (base_addr !== 9'd42) $display("FAIL a23_base: got %0d want 42", base_addr); else pass_cnt++;
      total_cnt++; if (alloc_id !== 2'd1) $display("FAIL a23_id: got %0d want 1", alloc_id); else pass_cnt++;
      step();
      total_cnt++; if (addr_ready !== 1'b0) $display("FAIL a23_ready_pulse: got %b want 0", addr_ready); else pass_cnt++;
      do_commit();
      do_lookup(3'd2, 3'd3, 2'd1);
      total_cnt++; if ({lk_hit, lk_base, lk_count} !== {1'b1, 9'd42, 2'd1}) $display("FAIL lk231: got hit=%b base=%0d cnt=%0d want 1/42/1", lk_hit, lk_base, lk_count); else pass_cnt++;
   endtask

   task automatic test_victim();
      do_alloc(3'd2, 3'd3); step();
      total_cnt++; if ({base_addr, alloc_id} !== {9'd48, 2'd2}) $display("FAIL a23_second: got base=%0d id=%0d want 48/2", base_addr, alloc_id); else pass_cnt++;
      step(); do_commit();
      do_alloc(3'd2, 3'd3); step();
      total_cnt++; if ({addr_ready, base_addr, alloc_id} !== {1'b1, 9'd42, 2'd1}) $display("FAIL a23_victim: got rdy=%b base=%0d id=%0d want 1/42/1", addr_ready, base_addr, alloc_id); else pass_cnt++;
      step();
      do_lookup(3'd2, 3'd3, 2'd1);
      total_cnt++; if ({lk_hit, lk_count} !== {1'b0, 2'd1}) $display("FAIL victim_miss: got hit=%b cnt=%0d want 0/1", lk_hit, lk_count); else pass_cnt++;
      do_commit();
      do_lookup(3'd2, 3'd3, 2'd1);
      total_cnt++; if ({lk_hit, lk_base, lk_count} !== {1'b1, 9'd42, 2'd2}) $display("FAIL victim_hit: got hit=%b base=%0d cnt=%0d want 1/42/2", lk_hit, lk_base, lk_count); else pass_cnt++;
   endtask

   task automatic test_boundary();
      do_alloc(3'd5, 3'd5); step();
      total_cnt++; if ({base_addr, alloc_id} !== {9'd400, 2'd1}) $display("FAIL a55_first: got base=%0d id=%0d want 400/1", base_addr, alloc_id); else pass_cnt++;
      step(); do_commit();
      do_alloc(3'd5, 3'd5); step();
      total_cnt++; if ({base_addr, alloc_id} !== {9'd425, 2'd2}) $display("FAIL a55_max: got base=%0d id=%0d want 425/2", base_addr, alloc_id); else pass_cnt++;
      step(); do_commit();
      do_alloc(3'd0, 3'd3);
      total_cnt++; if ({alloc_err, addr_ready} !== 2'b10) $display("FAIL err03: got err=%b rdy=%b want 1/0", alloc_err, addr_ready); else pass_cnt++;
      step();
      total_cnt++; if ({alloc_err, addr_ready} !== 2'b00) $display("FAIL err03_after: got err=%b rdy=%b want 0/0", alloc_err, addr_ready); else pass_cnt++;
      do_alloc(3'd6, 3'd1);
      total_cnt++; if (alloc_err !== 1'b1) $display("FAIL err61: got %b want 1", alloc_err); else pass_cnt++;
      step();
      total_cnt++; if ({alloc_err, addr_ready, base_addr} !== {2'b00, 9'd425}) $display("FAIL err61_after: got err=%b rdy=%b base=%0d want 0/0/425", alloc_err, addr_ready, base_addr); else pass_cnt++;
      do_lookup(3'd5, 3'd5, 2'd2);
      total_cnt++; if ({lk_hit, lk_base, lk_count} !== {1'b1, 9'd425, 2'd2}) $display("FAIL lk552: got hit=%b base=%0d cnt=%0d want 1/425/2", lk_hit, lk_base, lk_count); else pass_cnt++;
      do_lookup(3'd5, 3'd5, 2'd0);
      total_cnt++; if ({lk_hit, lk_base, lk_count} !== {1'b0, 9'd0, 2'd2}) $display("FAIL lk_id0: got hit=%b base=%0d cnt=%0d want 0/0/2", lk_hit, lk_base, lk_count); else pass_cnt++;
      do_lookup(3'd5, 3'd5, 2'd3);
      total_cnt++; if ({lk_hit, lk_base} !== {1'b0, 9'd0}) $display("FAIL lk_id3: got hit=%b base=%0d want 0/0", lk_hit, lk_base); else pass_cnt++;
      do_lookup(3'd0, 3'd1, 2'd1);
      total_cnt++; if ({lk_hit, lk_base, lk_count} !== {1'b0, 9'd0, 2'd0}) $display("FAIL lk_bad_dims: got hit=%b base=%0d cnt=%0d want 0/0/0", lk_hit, lk_base, lk_count); else pass_cnt++;
   endtask

   task automatic test_implicit_commit();
      do_alloc(3'd3, 3'd3); step();
      total_cnt++; if ({base_addr, alloc_id} !== {9'd108, 2'd1}) $display("FAIL a33_first: got base=%0d id=%0d want 108/1", base_addr, alloc_id); else pass_cnt++;
      step();
      do_alloc(3'd3, 3'd3); step();
      total_cnt++; if ({addr_ready, base_addr, alloc_id} !== {1'b1, 9'd117, 2'd2}) $display("FAIL a33_implicit: got rdy=%b base=%0d id=%0d want 1/117/2", addr_ready, base_addr, alloc_id); else pass_cnt++;
      step(); do_commit();
      do_lookup(3'd3, 3'd3, 2'd1);
      total_cnt++; if ({lk_hit, lk_base, lk_count} !== {1'b1, 9'd108, 2'd2}) $display("FAIL lk331: got hit=%b base=%0d cnt=%0d want 1/108/2", lk_hit, lk_base, lk_count); else pass_cnt++;
   endtask

   task automatic test_arbiter();
      in_we = 1'b1; cp_req = 1'b1; cp_addr = 9'h022; cp_data = 32'h5A5A_0022;
      for (int i = 0; i < 3; i++) begin
         in_addr = 9'(16 + i); in_data = 32'hA5A5_0000 + 32'(i);
         #1;
         total_cnt++; if ({mem_we, cp_gnt, mem_addr, mem_data} !== {2'b10, 9'(16 + i), 32'hA5A5_0000 + 32'(i)}) $display("FAIL arb_in_prio%0d: got we=%b gnt=%b addr=%h data=%h", i, mem_we, cp_gnt, mem_addr, mem_data); else pass_cnt++;
         step();
      end
      in_we = 1'b0;
      #1;
      total_cnt++; if ({mem_we, cp_gnt, mem_addr, mem_data} !== {2'b11, 9'h022, 32'h5A5A_0022}) $display("FAIL arb_cp_gnt: got we=%b gnt=%b addr=%h data=%h want 1/1/022/5a5a0022", mem_we, cp_gnt, mem_addr, mem_data); else pass_cnt++;
      step();
      cp_req = 1'b0;
      #1;
      total_cnt++; if ({mem_we, cp_gnt, mem_addr, mem_data} !== {2'b00, 9'h022, 32'h5A5A_0022}) $display("FAIL arb_hold: got we=%b gnt=%b addr=%h data=%h want 0/0/022/5a5a0022", mem_we, cp_gnt, mem_addr, mem_data); else pass_cnt++;
      step();
   endtask

   task automatic test_clear_commit();
      do_alloc(3'd4, 3'd2); step();
      total_cnt++; if (base_addr !== 9'd188) $display("FAIL a42_base: got %0d want 188", base_addr); else pass_cnt++;
      step();
      commit = 1'b1; clear_all = 1'b1;
      step();
      commit = 1'b0; clear_all = 1'b0;
      do_lookup(3'd4, 3'd2, 2'd1);
      total_cnt++; if ({lk_hit, lk_count} !== {1'b0, 2'd0}) $display("FAIL clr_lk42: got hit=%b cnt=%0d want 0/0", lk_hit, lk_count); else pass_cnt++;
      do_lookup(3'd2, 3'd3, 2'd2);
      total_cnt++; if ({lk_hit, lk_count} !== {1'b0, 2'd0}) $display("FAIL clr_lk23: got hit=%b cnt=%0d want 0/0", lk_hit, lk_count); else pass_cnt++;
      do_lookup(3'd5, 3'd5, 2'd1);
      total_cnt++; if ({lk_hit, lk_count} !== {1'b0, 2'd0}) $display("FAIL clr_lk55: got hit=%b cnt=%0d want 0/0", lk_hit, lk_count); else pass_cnt++;
      do_alloc(3'd2, 3'd3); step();
      total_cnt++; if ({addr_ready, base_addr, alloc_id} !== {1'b1, 9'd42, 2'd1}) $display("FAIL clr_realloc: got rdy=%b base=%0d id=%0d want 1/42/1", addr_ready, base_addr, alloc_id); else pass_cnt++;
      step(); do_commit();
   endtask

   task automatic test_async_reset();
      do_alloc(3'd1, 3'd2); step();
      total_cnt++; if ({base_addr, alloc_id} !== {9'd2, 2'd1}) $display("FAIL a12_first: got base=%0d id=%0d want 2/1", base_addr, alloc_id); else pass_cnt++;
      step(); do_commit();
      do_alloc(3'd1, 3'd2); step();
      total_cnt++; if ({base_addr, alloc_id} !== {9'd4, 2'd2}) $display("FAIL a12_second: got base=%0d id=%0d want 4/2", base_addr, alloc_id); else pass_cnt++;
      step();
      do_lookup(3'd1, 3'd2, 2'd1);
      total_cnt++; if ({lk_hit, lk_base, lk_count} !== {1'b1, 9'd2, 2'd1}) $display("FAIL lk121_pre: got hit=%b base=%0d cnt=%0d want 1/2/1", lk_hit, lk_base, lk_count); else pass_cnt++;
      in_we = 1'b1; in_addr = 9'h1F3; in_data = 32'hDEAD_BEEF;
      #2 rst = 1'b1;
      #1;
      total_cnt++; if ({addr_ready, alloc_err, alloc_id, base_addr} !== 14'd0) $display("FAIL arst_alloc_outs: got %h want 0", {addr_ready, alloc_err, alloc_id, base_addr}); else pass_cnt++;
      total_cnt++; if ({lk_hit, lk_count, lk_base} !== 12'd0) $display("FAIL arst_lookup_outs: got %h want 0", {lk_hit, lk_count, lk_base}); else pass_cnt++;
      total_cnt++; if ({cp_gnt, mem_we, mem_addr, mem_data} !== 43'd0) $display("FAIL arst_mem_outs: got %h want 0", {cp_gnt, mem_we, mem_addr, mem_data}); else pass_cnt++;
      in_we = 1'b0;
      step();
      rst = 1'b0;
      do_lookup(3'd1, 3'd2, 2'd1);
      total_cnt++; if ({lk_hit, lk_count} !== {1'b0, 2'd0}) $display("FAIL arst_lk121: got hit=%b cnt=%0d want 0/0", lk_hit, lk_count); else pass_cnt++;
      do_alloc(3'd1, 3'd2); step();
      total_cnt++; if ({addr_ready, base_addr, alloc_id} !== {1'b1, 9'd2, 2'd1}) $display("FAIL arst_realloc: got rdy=%b base=%0d id=%0d want 1/2/1", addr_ready, base_addr, alloc_id); else pass_cnt++;
   endtask

   initial begin
      rst = 1'b1;
      alloc_req = 1'b0; alloc_m = '0; alloc_n = '0;
      commit = 1'b0; abort = 1'b0; clear_all = 1'b0;
      lk_m = '0; lk_n = '0; lk_id = '0;
      in_we = 1'b0; in_addr = '0; in_data = '0;
      cp_req = 1'b0; cp_addr = '0; cp_data = '0;
      test_reset();
      test_alloc_basic();
      test_victim();
      test_boundary();
      test_implicit_commit();
      test_arbiter();
      test_clear_commit();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
